// File: rtl/chips_pkg.sv
// Shared types and constants for the chips stb/ack responder block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package chips_pkg;

   // Default operand/result width.
   localparam int CHIPS_WIDTH = 64;

   // Responder FSM states.
   typedef enum logic [1:0] {
      GET_AB = 2'd0,   // collecting operands A and B
      RUN    = 2'd1,   // waiting for the compute core to finish
      PUT_Z  = 2'd2    // offering the result to the initiator
   } chips_resp_state_t;

endpackage : chips_pkg

// File: rtl/chips_responder_if.sv
// Bundle of the responder's protocol signals: initiator-side operand/result
// stb/ack channels, the compute-core op_* handshake and the transfer counter.
// Modports: slave = responder side, master = initiator/core side.
interface chips_responder_if
   import chips_pkg::*;
#(
   parameter int WIDTH = CHIPS_WIDTH
);

   // Operand A channel
   logic [WIDTH-1:0] input_a;
   logic             input_a_stb;
   logic             input_a_ack;
   // Operand B channel
   logic [WIDTH-1:0] input_b;
   logic             input_b_stb;
   logic             input_b_ack;
   // Result channel
   logic [WIDTH-1:0] output_z;
   logic             output_z_stb;
   logic             output_z_ack;
   // Compute-core handshake
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             op_start;
   logic [WIDTH-1:0] op_result;
   logic             op_done;
   logic             op_busy;
   // Completed result transfers
   logic [15:0]      txn_count;

   modport slave (
      input  input_a, input_a_stb,
      output input_a_ack,
      input  input_b, input_b_stb,
      output input_b_ack,
      output output_z, output_z_stb,
      input  output_z_ack,
      output op_a, op_b, op_start,
      input  op_result, op_done,
      output op_busy, txn_count
   );

   modport master (
      output input_a, input_a_stb,
      input  input_a_ack,
      output input_b, input_b_stb,
      input  input_b_ack,
      input  output_z, output_z_stb,
      output output_z_ack,
      input  op_a, op_b, op_start,
      output op_result, op_done,
      input  op_busy, txn_count
   );

endinterface : chips_responder_if

// File: rtl/chips_rx_port.sv
// One operand receive port: offers ack while armed and not yet captured,
// latches data on the stb&ack edge; latency 1 edge from handshake to data_o.
// Backpressure: ack stays low after capture until clear_i re-opens the port.
// Ports: clock/reset_n; data_i/stb_i/ack_o initiator channel; arm_i allows
// ack to rise; clear_i drops the captured flag and raises ack; data_o,
// captured_o registered outputs; hs_o is the handshake happening this cycle.
module chips_rx_port
   import chips_pkg::*;
#(
   parameter int WIDTH = CHIPS_WIDTH
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] data_i,
   input  logic             stb_i,
   output logic             ack_o,
   input  logic             arm_i,
   input  logic             clear_i,
   output logic [WIDTH-1:0] data_o,
   output logic             captured_o,
   output logic             hs_o
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             ack_q, ack_d;
   logic             captured_q, captured_d;

   // ack_q is a flop, so the handshake decode never feeds an output directly.
   assign hs_o = ack_q & stb_i;

   always_comb begin
      data_d     = data_q;
      ack_d      = ack_q;
      captured_d = captured_q;
      if (clear_i) begin
         // Result delivered: reopen for the next transaction.
         captured_d = 1'b0;
         ack_d      = 1'b1;
      end else if (hs_o) begin
         data_d     = data_i;
         captured_d = 1'b1;
         ack_d      = 1'b0;
      end else if (arm_i && !captured_q) begin
         // Covers the first edge after reset, when nothing has set ack yet.
         ack_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         data_q     <= '0;
         ack_q      <= 1'b0;
         captured_q <= 1'b0;
      end else begin
         data_q     <= data_d;
         ack_q      <= ack_d;
         captured_q <= captured_d;
      end
   end

   assign ack_o      = ack_q;
   assign data_o     = data_q;
   assign captured_o = captured_q;

endmodule : chips_rx_port

// File: rtl/chips_responder.sv
// Chips stb/ack responder: gathers A and B, starts the core, returns Z.
// Latency: start 1 edge after last operand, Z 1 edge after op_done.
// Backpressure: Z held with stb until output_z_ack; operand acks low meanwhile.
// Ports: clock, reset_n (async, active-low); bus = slave side of
// chips_responder_if carrying the A/B/Z channels, op_* core handshake and
// txn_count.
module chips_responder
   import chips_pkg::*;
#(
   parameter int WIDTH = CHIPS_WIDTH
) (
   input  logic             clock,
   input  logic             reset_n,
   chips_responder_if.slave bus
);

   chips_resp_state_t state_q, state_d;

   logic             op_start_q, op_start_d;
   logic             op_busy_q, op_busy_d;
   logic [WIDTH-1:0] z_q, z_d;
   logic             z_stb_q, z_stb_d;
   logic [15:0]      txn_count_q, txn_count_d;

   logic             clear_ports;
   logic             arm_ports;
   logic             a_ack, b_ack;
   logic             a_cap, b_cap;
   logic             a_hs, b_hs;
   logic [WIDTH-1:0] a_dat, b_dat;

   assign arm_ports = (state_q == GET_AB);

   chips_rx_port #(.WIDTH(WIDTH)) u_rx_a (
      .clock      (clock),
      .reset_n    (reset_n),
      .data_i     (bus.input_a),
      .stb_i      (bus.input_a_stb),
      .ack_o      (a_ack),
      .arm_i      (arm_ports),
      .clear_i    (clear_ports),
      .data_o     (a_dat),
      .captured_o (a_cap),
      .hs_o       (a_hs)
   );

   chips_rx_port #(.WIDTH(WIDTH)) u_rx_b (
      .clock      (clock),
      .reset_n    (reset_n),
      .data_i     (bus.input_b),
      .stb_i      (bus.input_b_stb),
      .ack_o      (b_ack),
      .arm_i      (arm_ports),
      .clear_i    (clear_ports),
      .data_o     (b_dat),
      .captured_o (b_cap),
      .hs_o       (b_hs)
   );

   always_comb begin
      state_d     = state_q;
      op_start_d  = 1'b0;
      op_busy_d   = op_busy_q;
      z_d         = z_q;
      z_stb_d     = z_stb_q;
      txn_count_d = txn_count_q;
      clear_ports = 1'b0;
      unique case (state_q)
         GET_AB: begin
            // Leave on the edge that completes the set, whichever operand
            // arrives last (or both on the same edge).
            if ((a_cap || a_hs) && (b_cap || b_hs)) begin
               state_d    = RUN;
               op_start_d = 1'b1;
               op_busy_d  = 1'b1;
            end
         end
         RUN: begin
            // Also taken on the edge where op_start is still high.
            if (bus.op_done) begin
               z_d       = bus.op_result;
               z_stb_d   = 1'b1;
               op_busy_d = 1'b0;
               state_d   = PUT_Z;
            end
         end
         PUT_Z: begin
            // z_stb_q is high for the whole state, so ack alone completes it.
            if (bus.output_z_ack) begin
               z_stb_d     = 1'b0;
               txn_count_d = txn_count_q + 16'd1;
               clear_ports = 1'b1;
               state_d     = GET_AB;
            end
         end
         default: begin
            state_d = GET_AB;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= GET_AB;
         op_start_q  <= 1'b0;
         op_busy_q   <= 1'b0;
         z_q         <= '0;
         z_stb_q     <= 1'b0;
         txn_count_q <= '0;
      end else begin
         state_q     <= state_d;
         op_start_q  <= op_start_d;
         op_busy_q   <= op_busy_d;
         z_q         <= z_d;
         z_stb_q     <= z_stb_d;
         txn_count_q <= txn_count_d;
      end
   end

   assign bus.input_a_ack  = a_ack;
   assign bus.input_b_ack  = b_ack;
   assign bus.output_z     = z_q;
   assign bus.output_z_stb = z_stb_q;
   assign bus.op_a         = a_dat;
   assign bus.op_b         = b_dat;
   assign bus.op_start     = op_start_q;
   assign bus.op_busy      = op_busy_q;
   assign bus.txn_count    = txn_count_q;

endmodule : chips_responder

// File: doc/chips_responder.md
CHIPS_RESPONDER -- requirements
Module: chips_responder

Interface
REQ-001 SHALL have parameter: WIDTH, default 64, data width of operands and result.
REQ-002 SHALL have ports:
- clock  input  1  sole clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- input_a  input  WIDTH  operand A from initiator.
- input_a_stb  input  1  A valid.
- input_a_ack  output  1  A accepted.
- input_b  input  WIDTH  operand B from initiator.
- input_b_stb  input  1  B valid.
- input_b_ack  output  1  B accepted.
- output_z  output  WIDTH  result to initiator.
- output_z_stb  output  1  result valid.
- output_z_ack  input  1  result taken.
- op_a  output  WIDTH  captured A to compute core.
- op_b  output  WIDTH  captured B to compute core.
- op_start  output  1  one-cycle start pulse to core.
- op_result  input  WIDTH  core result.
- op_done  input  1  core result valid, single-cycle.
- op_busy  output  1  core operation outstanding.
- txn_count  output  16  completed result transfers.

Function
REQ-003 SHALL implement the responder end of the chips stb/ack protocol. A transfer completes on any rising edge where stb and ack are both high.
REQ-004 SHALL use states GET_AB, RUN, PUT_Z.
REQ-005 SHALL drive all protocol and op_* outputs from flops, with no combinational path from inputs to outputs.
REQ-006 GET_AB behaviour:
- Per operand, while not yet captured: ack is set to 1.
- On the handshake edge: the operand is latched and ack is cleared.
- A and B are accepted independently, in either order or on the same edge.
- A second stb on an already-captured operand is ignored, and its ack stays 0.
REQ-007 On the edge that captures the last outstanding operand:
- state goes to RUN;
- op_start goes to 1 for exactly one cycle;
- op_a/op_b present the captured values and hold them until the next capture.
REQ-008 RUN behaviour:
- op_busy = 1.
- op_done is honoured on any edge in RUN, including the edge where op_start is high.
- op_done outside RUN is ignored.
REQ-009 On the op_done edge in RUN:
- output_z takes op_result;
- output_z_stb goes to 1;
- op_busy goes to 0;
- state goes to PUT_Z.
REQ-010 PUT_Z behaviour:
- output_z and output_z_stb are held stable until the handshake edge, with no timeout.
- On the handshake edge: output_z_stb goes to 0, txn_count increments, state goes to GET_AB, both capture flags clear, and both acks go to 1.
REQ-011 txn_count SHALL wrap from 0xFFFF to 0x0000.
REQ-012 Back-to-back throughput SHALL be at most one transaction per (operand handshake + core latency + 2) cycles, with no extra idle cycle after PUT_Z.
REQ-013 output_z SHALL retain its last value outside PUT_Z.

Reset
REQ-014 reset_n low SHALL asynchronously force:
- state GET_AB;
- capture flags 0;
- input_a_ack, input_b_ack, output_z_stb, op_start, op_busy = 0;
- output_z, op_a, op_b = 0;
- txn_count = 0.
REQ-015 input_a_ack and input_b_ack SHALL rise on the first rising edge after reset_n deasserts.
REQ-016 Reset asserted mid-transaction (any state) SHALL abandon the transaction: no stb, start or count is produced for it.

Structure
REQ-017 Shared package chips_pkg SHALL hold:
- the state enum chips_resp_state_t (GET_AB, RUN, PUT_Z);
- the constant CHIPS_WIDTH = 64.
REQ-018 Operand capture SHALL be the sub-module chips_rx_port (data, stb, ack, captured flag, clear), instantiated for A and B.
REQ-019 The top level SHALL hold the FSM, the op_* handshake, the output_z register and txn_count.

Verification
REQ-020 A=0x3FF0000000000000 and B=0x4000000000000000 presented on the same cycle; core returns 0x4008000000000000 after 3 cycles; initiator acks immediately:
- both captured on one edge;
- one op_start pulse;
- output_z=0x4008000000000000 with stb high for 1 cycle;
- txn_count=1.
REQ-021 A stb 5 cycles before B stb:
- input_a_ack drops after the A handshake while input_b_ack stays 1;
- op_start only follows the B handshake;
- op_a/op_b are correct.
REQ-022 op_done on the same cycle as op_start, initiator delays output_z_ack 10 cycles:
- output_z_stb and output_z are stable for all 10 cycles;
- acks stay 0 until the handshake edge.
REQ-023 reset_n pulsed low during RUN, then op_done asserted:
- all outputs return to reset values immediately;
- op_done is ignored;
- no output_z_stb;
- txn_count=0;
- acks rise 1 edge after release.
REQ-024 65537 back-to-back transactions SHALL yield txn_count=0x0001.
REQ-025 Extra input_a_stb held high while waiting for B SHALL leave op_a unchanged and produce no second capture.
